// File: rtl/uc_pkg.sv
// Shared types and constants for the multicycle control unit:
// state encodings, opcode fields, ALU operation codes and the decoded control tuple.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_STOP   = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        ALU_OP_000 = 3'b000,
        ALU_OP_001 = 3'b001,
        ALU_OP_010 = 3'b010,
        ALU_OP_011 = 3'b011,
        ALU_OP_100 = 3'b100,
        ALU_OP_101 = 3'b101,
        ALU_OP_110 = 3'b110,
        ALU_OP_111 = 3'b111
    } alu_op_t;

    // Conditional branches keep their kind so s_inc can follow the live z in EXEC.
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_JZ   = 2'b01,
        BR_JNZ  = 2'b10
    } br_t;

    localparam logic [5:0] OP_NOP     = 6'b000000;
    localparam logic [5:0] OP_JMP     = 6'b000001;
    localparam logic [5:0] OP_JZ      = 6'b000010;
    localparam logic [5:0] OP_JNZ     = 6'b000011;
    localparam logic [5:0] OP_HALT    = 6'b000111;
    localparam logic [3:0] OP_LI_PFX  = 4'b0100;
    localparam int         OP_ALU_BIT = 5;

    typedef struct packed {
        logic    s_inc;
        logic    s_inm;
        logic    we3;
        logic    wez;
        alu_op_t op_alu;
        br_t     br;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        s_inc:  1'b1,
        s_inm:  1'b0,
        we3:    1'b0,
        wez:    1'b0,
        op_alu: ALU_OP_000,
        br:     BR_NONE
    };

endpackage

// File: rtl/uc_decode.sv
// Combinational instruction decoder: opcode and zero flag to the control tuple.
// Unknown opcodes (including HALT, which the FSM handles) decode as nop.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic       i_z,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        if (i_opcode[OP_ALU_BIT]) begin
            o_ctrl.we3    = 1'b1;
            o_ctrl.wez    = 1'b1;
            o_ctrl.op_alu = alu_op_t'(i_opcode[4:2]);
        end else if (i_opcode[5:2] == OP_LI_PFX) begin
            o_ctrl.s_inm = 1'b1;
            o_ctrl.we3   = 1'b1;
        end else begin
            case (i_opcode)
                OP_NOP: ;
                OP_JMP: o_ctrl.s_inc = 1'b0;
                OP_JZ: begin
                    o_ctrl.s_inc = ~i_z;
                    o_ctrl.br    = BR_JZ;
                end
                OP_JNZ: begin
                    o_ctrl.s_inc = i_z;
                    o_ctrl.br    = BR_JNZ;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC sequencing with memory handshake,
// registered decode, sticky HALT and fetch-timeout ERROR.
//
// state  | meaning
// FETCH  | request program word, count wait cycles, load IR on ack
// DECODE | latch decoded controls from the IR opcode
// EXEC   | drive controls, one-cycle PC/regfile/flag strobes
// STOP   | sticky halt or fetch timeout; leave only through reset
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic       i_z,
    input  logic       i_mem_ack,
    output logic       o_mem_req,
    output logic       o_ir_we,
    output logic       o_pc_we,
    output logic       o_s_inc,
    output logic       o_s_inm,
    output logic       o_we3,
    output logic       o_wez,
    output logic [2:0] o_op_alu,
    output logic       o_halted,
    output logic       o_error,
    output logic [1:0] o_state
);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    ctrl_t            r_ctrl, w_ctrl_next, w_dec;
    logic             r_halted, w_halted_next;
    logic             r_error, w_error_next;

    uc_decode u_decode (
        .i_opcode (i_opcode),
        .i_z      (i_z),
        .o_ctrl   (w_dec)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_FETCH;
            r_cnt    <= '0;
            r_ctrl   <= CTRL_IDLE;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_ctrl   <= w_ctrl_next;
            r_halted <= w_halted_next;
            r_error  <= w_error_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_ctrl_next   = r_ctrl;
        w_halted_next = r_halted;
        w_error_next  = r_error;
        o_mem_req     = 1'b0;
        o_ir_we       = 1'b0;
        o_pc_we       = 1'b0;
        o_s_inc       = 1'b1;
        o_s_inm       = 1'b0;
        o_we3         = 1'b0;
        o_wez         = 1'b0;
        o_op_alu      = ALU_OP_000;

        case (r_state)
            ST_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    o_ir_we      = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_DECODE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_next = ST_STOP;
                    w_error_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                w_ctrl_next = w_dec;
                if (i_opcode == OP_HALT) begin
                    w_state_next  = ST_STOP;
                    w_halted_next = 1'b1;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_pc_we  = 1'b1;
                o_s_inm  = r_ctrl.s_inm;
                o_we3    = r_ctrl.we3;
                o_wez    = r_ctrl.wez;
                o_op_alu = r_ctrl.op_alu;
                case (r_ctrl.br)
                    BR_JZ:   o_s_inc = ~i_z;
                    BR_JNZ:  o_s_inc = i_z;
                    default: o_s_inc = r_ctrl.s_inc;
                endcase
                w_state_next = ST_FETCH;
            end
            default: ;
        endcase

        // Reset must not let a strobe through in the cycle it is asserted.
        if (i_reset) begin
            o_mem_req = 1'b0;
            o_ir_we   = 1'b0;
            o_pc_we   = 1'b0;
            o_s_inc   = 1'b1;
            o_s_inm   = 1'b0;
            o_we3     = 1'b0;
            o_wez     = 1'b0;
            o_op_alu  = ALU_OP_000;
        end
    end

    assign o_halted = r_halted;
    assign o_error  = r_error;
    assign o_state  = r_state;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: scenario tasks with randomized opcodes,
// z values and memory wait states against a per-instruction reference model.
module tb_uc_multiciclo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       z = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, halted, error;
    logic [2:0] op_alu;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uc_multiciclo #(.TIMEOUT(16), .CNT_W(5)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_opcode  (opcode),
        .i_z       (z),
        .i_mem_ack (mem_ack),
        .o_mem_req (mem_req),
        .o_ir_we   (ir_we),
        .o_pc_we   (pc_we),
        .o_s_inc   (s_inc),
        .o_s_inm   (s_inm),
        .o_we3     (we3),
        .o_wez     (wez),
        .o_op_alu  (op_alu),
        .o_halted  (halted),
        .o_error   (error),
        .o_state   (state)
    );

    // Expected EXEC tuple {s_inc, s_inm, we3, wez, op_alu} from the instruction table.
    function automatic logic [6:0] model_exec(input logic [5:0] op, input logic zv);
        logic       e_inc, e_inm, e_we3, e_wez;
        logic [2:0] e_alu;
        e_inc = 1'b1; e_inm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0; e_alu = 3'b000;
        if (op >= 6'd32) begin
            e_we3 = 1'b1; e_wez = 1'b1; e_alu = 3'((op - 6'd32) / 4);
        end else if (op >= 6'd16 && op <= 6'd19) begin
            e_inm = 1'b1; e_we3 = 1'b1;
        end else if (op == 6'd1) begin
            e_inc = 1'b0;
        end else if (op == 6'd2) begin
            e_inc = (zv == 1'b0);
        end else if (op == 6'd3) begin
            e_inc = (zv == 1'b1);
        end
        return {e_inc, e_inm, e_we3, e_wez, e_alu};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one #1 into the first FETCH cycle after reset.
    task automatic do_reset();
        reset = 1'b1;
        mem_ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // One instruction starting at a FETCH cycle: `waits` no-ack cycles, then ack, DECODE, EXEC.
    task automatic exec_instr(input logic [5:0] op, input int waits, input logic z_exec);
        logic [6:0] exp_t;
        for (int w = 0; w < waits; w++) begin
            mem_ack = 1'b0; opcode = 6'($urandom); z = 1'($urandom);
            #1;
            checks++;
            if ({state, mem_req, ir_we, pc_we, we3, wez} !== {2'b00, 1'b1, 4'b0000}) begin
                errors++;
                $display("FAIL fetch_wait: w=%0d state=%b req=%b ir=%b pc=%b we3=%b wez=%b, expected state=00 req=1 strobes=0",
                         w, state, mem_req, ir_we, pc_we, we3, wez);
            end
            tick();
        end
        mem_ack = 1'b1; opcode = 6'($urandom); z = 1'($urandom);
        #1;
        checks++;
        if ({state, mem_req, ir_we, pc_we, we3, wez} !== {2'b00, 1'b1, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL fetch_ack: state=%b req=%b ir=%b pc=%b we3=%b wez=%b, expected state=00 req=1 ir=1 others=0",
                     state, mem_req, ir_we, pc_we, we3, wez);
        end
        tick();
        mem_ack = 1'($urandom); opcode = op; z = 1'($urandom);
        #1;
        checks++;
        if ({state, mem_req, ir_we, pc_we, we3, wez, s_inc, s_inm, op_alu} !== {2'b01, 5'b00000, 1'b1, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL decode: op=%b state=%b req=%b ir=%b pc=%b we3=%b wez=%b s_inc=%b s_inm=%b alu=%b, expected state=01 idle outputs",
                     op, state, mem_req, ir_we, pc_we, we3, wez, s_inc, s_inm, op_alu);
        end
        tick();
        mem_ack = 1'($urandom); opcode = 6'($urandom); z = z_exec;
        #1;
        exp_t = model_exec(op, z_exec);
        checks++;
        if ({state, mem_req, ir_we, pc_we} !== {2'b10, 1'b0, 1'b0, 1'b1} ||
            {s_inc, s_inm, we3, wez, op_alu} !== exp_t) begin
            errors++;
            $display("FAIL exec: op=%b z=%b state=%b req=%b ir=%b pc=%b tuple=%b, expected state=10 req=0 ir=0 pc=1 tuple=%b",
                     op, z_exec, state, mem_req, ir_we, pc_we, {s_inc, s_inm, we3, wez, op_alu}, exp_t);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b1;
        tick();
        tick();
        checks++;
        if ({ir_we, pc_we, we3, wez, s_inc, s_inm, op_alu, halted, error} !== {4'b0000, 1'b1, 1'b0, 3'b000, 2'b00}) begin
            errors++;
            $display("FAIL reset_held: ir=%b pc=%b we3=%b wez=%b s_inc=%b s_inm=%b alu=%b halted=%b error=%b, expected idle",
                     ir_we, pc_we, we3, wez, s_inc, s_inm, op_alu, halted, error);
        end
        reset = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if ({state, mem_req, ir_we, pc_we, we3, wez, s_inc, halted, error} !== {2'b00, 1'b1, 4'b0000, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL reset_release: state=%b req=%b ir=%b pc=%b we3=%b wez=%b s_inc=%b halted=%b error=%b, expected FETCH req=1 idle",
                     state, mem_req, ir_we, pc_we, we3, wez, s_inc, halted, error);
        end
        tick();
    endtask

    task automatic test_alu_stream();
        do_reset();
        for (int i = 0; i < 3; i++) exec_instr(6'b101000, 0, 1'($urandom));
        for (int i = 0; i < 8; i++) exec_instr(6'($urandom_range(32, 63)), 0, 1'($urandom));
    endtask

    task automatic test_branches();
        do_reset();
        exec_instr(6'b000010, 0, 1'b1);
        exec_instr(6'b000010, 0, 1'b0);
        exec_instr(6'b000011, 0, 1'b1);
        exec_instr(6'b000011, 0, 1'b0);
        exec_instr(6'b000001, 0, 1'($urandom));
        exec_instr(6'b000000, 0, 1'($urandom));
    endtask

    task automatic test_li();
        exec_instr(6'b010011, 0, 1'($urandom));
        exec_instr(6'($urandom_range(16, 19)), 1, 1'($urandom));
    endtask

    task automatic test_wait_states();
        exec_instr(6'b101000, 5, 1'($urandom));
        exec_instr(6'b000010, 15, 1'b1);
    endtask

    task automatic test_random_program();
        logic [5:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 6'($urandom);
            if (op == 6'b000111) op = 6'b000000;
            exec_instr(op, int'($urandom_range(0, 4)), 1'($urandom));
        end
    endtask

    task automatic test_timeout();
        int fetch_cycles;
        do_reset();
        fetch_cycles = 0;
        for (int c = 0; c < 40 && state == 2'b00; c++) begin
            mem_ack = 1'b0;
            fetch_cycles++;
            tick();
        end
        #1;
        checks++;
        if (fetch_cycles !== 16) begin
            errors++;
            $display("FAIL timeout_len: fetch cycles=%0d, expected 16", fetch_cycles);
        end
        checks++;
        if ({state, error, halted, mem_req, ir_we, pc_we, we3, wez} !== {2'b11, 1'b1, 6'b000000}) begin
            errors++;
            $display("FAIL timeout_stop: state=%b error=%b halted=%b req=%b strobes=%b, expected 11 1 0 0 0000",
                     state, error, halted, mem_req, {ir_we, pc_we, we3, wez});
        end
        for (int c = 0; c < 6; c++) begin
            mem_ack = 1'($urandom); opcode = 6'($urandom);
            tick();
        end
        checks++;
        if ({state, error, mem_req} !== {2'b11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_sticky: state=%b error=%b req=%b, expected 11 1 0", state, error, mem_req);
        end
        do_reset();
        #1;
        checks++;
        if ({state, error, mem_req} !== {2'b00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_reset: state=%b error=%b req=%b, expected 00 0 1", state, error, mem_req);
        end
    endtask

    task automatic test_halt();
        do_reset();
        exec_instr(6'b101100, 0, 1'b0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; opcode = 6'b000111;
        #1;
        checks++;
        if ({state, halted} !== {2'b01, 1'b0}) begin
            errors++;
            $display("FAIL halt_decode: state=%b halted=%b, expected 01 0", state, halted);
        end
        tick();
        opcode = 6'($urandom);
        for (int c = 0; c < 5; c++) begin
            mem_ack = 1'($urandom); z = 1'($urandom);
            #1;
            checks++;
            if ({state, halted, error, mem_req, ir_we, pc_we, we3, wez} !== {2'b11, 1'b1, 6'b000000}) begin
                errors++;
                $display("FAIL halt_stop: c=%0d state=%b halted=%b error=%b req=%b strobes=%b, expected 11 1 0 0 0000",
                         c, state, halted, error, mem_req, {ir_we, pc_we, we3, wez});
            end
            tick();
        end
        do_reset();
        #1;
        checks++;
        if ({state, halted} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL halt_reset: state=%b halted=%b, expected 00 0", state, halted);
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; opcode = 6'b101000;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({pc_we, we3, wez} !== 3'b000) begin
            errors++;
            $display("FAIL reset_exec_strobes: pc=%b we3=%b wez=%b, expected 000", pc_we, we3, wez);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({state, mem_req, we3} !== {2'b00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_exec_after: state=%b req=%b we3=%b, expected 00 1 0", state, mem_req, we3);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_branches();
        test_li();
        test_wait_states();
        test_random_program();
        test_timeout();
        test_halt();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multicycle control unit that sequences the existing PC / instruction register / register file / ALU datapath through FETCH, DECODE and EXEC.
- Stalls on a program-memory request/acknowledge handshake.
- Instructions are decoded once and held in registered controls.
- Write strobes (we3, wez, pc_we) assert for exactly one cycle per instruction. Adds sticky HALT and fetch-timeout ERROR states.

Parameters:
- TIMEOUT, 16, maximum cycles FETCH waits for mem_ack before entering ERROR (minimum 1).
- CNT_W, 5, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instruction register opcode field; valid from the cycle after ir_we
- z  input  1  registered zero flag from datapath
- mem_ack  input  1  program memory word valid this cycle
- mem_req  output  1  fetch request to program memory
- ir_we  output  1  load instruction register (one cycle)
- pc_we  output  1  update PC (one cycle, EXEC only)
- s_inc  output  1  PC source: 1 = PC+1, 0 = jump target
- s_inm  output  1  register-file write source: 1 = immediate, 0 = ALU
- we3  output  1  register-file write enable
- wez  output  1  zero-flag write enable
- op_alu  output  3  ALU operation
- halted  output  1  sticky HALT indicator
- error  output  1  sticky fetch-timeout indicator
- state  output  2  current state, for debug

Behaviour:
- Reset (synchronous, wins over every other event):
  - state = FETCH, wait counter = 0, decoded-control registers cleared.
  - Outputs: mem_req = 1 from the first cycle after reset; all other outputs at their idle values: ir_we = pc_we = we3 = wez = 0, s_inc = 1, s_inm = 0, op_alu = 000, halted = error = 0.
- States: FETCH = 00, DECODE = 01, EXEC = 10, STOP = 11. HALT vs ERROR inside STOP is distinguished by halted/error.
- FETCH:
  - mem_req = 1.
  - If mem_ack: ir_we = 1 in the same cycle, counter cleared, go to DECODE.
  - Otherwise counter++. When counter reaches TIMEOUT-1 without ack: go to STOP, error = 1.
- DECODE:
  - mem_req = 0; latch the decoded controls from opcode into registers; go to EXEC.
  - Opcode 000111: go to STOP, halted = 1.
- EXEC:
  - Drive the registered controls.
  - pc_we = 1; we3/wez as decoded; go to FETCH.
- Decode table (s_inc, s_inm, we3, wez, op_alu):
  - 000000 nop: 1, 0, 0, 0, 000.
  - 000001 jmp: 0, 0, 0, 0, 000.
  - 000010 jz: s_inc = ~z, others 0, 0, 0, 000.
  - 000011 jnz: s_inc = z, others 0, 0, 0, 000.
  - 0100xx li: 1, 1, 1, 0, 000.
  - 1ooo xx ALU: 1, 0, 1, 1, op_alu = ooo.
  - Any other opcode behaves as nop.
- z timing: sampled combinationally in EXEC, not DECODE. wez only pulses in EXEC, so z reflects the previous ALU instruction.
- Outside EXEC: pc_we = we3 = wez = 0, s_inc = 1, s_inm = 0, op_alu = 000. No datapath state changes outside EXEC.
- Latency: 3 cycles per instruction with zero-wait memory; 3 + N cycles with N wait cycles.
- STOP:
  - All strobes 0, mem_req = 0; remains in STOP until reset.
  - halted and error are mutually exclusive.
- Edge cases:
  - mem_ack outside FETCH is ignored.
  - Reset asserted mid-EXEC suppresses that cycle's strobes.

Decomposition:
- Package uc_pkg holds:
  - state encodings;
  - opcode constants: OP_NOP, OP_JMP, OP_JZ, OP_JNZ, OP_LI prefix, ALU prefix bit, OP_HALT;
  - ALU op codes 000..111.
- One combinational sub-module, uc_decode, maps opcode and z to the control tuple. The FSM registers its output in DECODE, except s_inc for jz/jnz, which is recomputed with the live z in EXEC.

Test Plan:
- Reset then mem_ack held 1, opcode 101000 (add) → ir_we at cycle 1, EXEC at cycle 3: we3 = wez = pc_we = 1, op_alu = 010, s_inc = 1; repeats every 3 cycles.
- opcode 000010 with z = 1 → in EXEC s_inc = 0, pc_we = 1, we3 = 0. Same with z = 0 → s_inc = 1. Repeat both for 000011 with the inverse result.
- opcode 010011 (li) → in EXEC s_inm = 1, we3 = 1, wez = 0, op_alu = 000.
- mem_ack low for 5 cycles then high, TIMEOUT = 16 → mem_req stays 1, no strobes during the wait, ir_we on the ack cycle, instruction completes 8 cycles after FETCH entry.
- mem_ack held 0 for 16 cycles → state = 11, error = 1, mem_req = 0. Stays there until reset; reset returns to FETCH with error = 0.
- opcode 000111 → no EXEC strobes, halted = 1 from the cycle after DECODE. Asserting reset during the EXEC cycle of a prior add → we3 = 0 that cycle, state = FETCH the next cycle.
